// File: rtl/branch_predictor_btb.sv
// Branch predictor: direct-mapped tagged BTB plus 2-bit counter BHT with bimodal or gshare indexing.
// Fetch lookups give a registered prediction one cycle later; exe retires resolved branches through the update port.
module branch_predictor_btb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ENTRIES  = 64,
    parameter int unsigned TAG_W    = 8,
    parameter int unsigned GHR_W    = 0,
    parameter logic [1:0]  CNT_INIT = 2'b01
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_lk_valid,
    input  logic            i_lk_stall,
    input  logic [XLEN-1:0] i_lk_pc,
    output logic            o_pred_valid,
    output logic            o_pred_hit,
    output logic            o_pred_taken,
    output logic [XLEN-1:0] o_pred_target,
    input  logic            i_upd_valid,
    input  logic [XLEN-1:0] i_upd_pc,
    input  logic            i_upd_taken,
    input  logic            i_upd_jump,
    input  logic [XLEN-1:0] i_upd_target
);

    localparam int unsigned IDX_W  = $clog2(ENTRIES);
    localparam int unsigned TAG_LO = IDX_W + 2;
    localparam int unsigned TAG_HI = TAG_LO + TAG_W - 1;

    logic [ENTRIES-1:0] r_btb_valid;
    logic [TAG_W-1:0]   r_btb_tag [ENTRIES];
    logic [XLEN-1:0]    r_btb_tgt [ENTRIES];
    logic [1:0]         r_cnt     [ENTRIES];

    logic [IDX_W-1:0] w_ghr_x;
    logic [IDX_W-1:0] w_lk_idx;
    logic [IDX_W-1:0] w_lk_bht;
    logic [TAG_W-1:0] w_lk_tag;
    logic [IDX_W-1:0] w_upd_idx;
    logic [IDX_W-1:0] w_upd_bht;
    logic [TAG_W-1:0] w_upd_tag;
    logic             w_lk_hit;
    logic             w_lk_taken;
    logic [1:0]       w_cnt_cur;
    logic [1:0]       w_cnt_nxt;
    logic             w_unused_hi;
    logic             w_unused;

    assign w_lk_idx  = i_lk_pc[IDX_W+1:2];
    assign w_lk_tag  = i_lk_pc[TAG_HI:TAG_LO];
    assign w_lk_bht  = w_lk_idx ^ w_ghr_x;
    assign w_upd_idx = i_upd_pc[IDX_W+1:2];
    assign w_upd_tag = i_upd_pc[TAG_HI:TAG_LO];
    assign w_upd_bht = w_upd_idx ^ w_ghr_x;

    assign w_lk_hit   = r_btb_valid[w_lk_idx] && (r_btb_tag[w_lk_idx] == w_lk_tag);
    assign w_lk_taken = w_lk_hit && r_cnt[w_lk_bht][1];
    assign w_cnt_cur  = r_cnt[w_upd_bht];

    // Global history: retired conditional branches only; folded onto IDX_W bits for indexing.
    generate
        if (GHR_W > 0) begin : g_gshare
            logic [GHR_W-1:0] r_ghr;
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_ghr <= '0;
                end else if (i_upd_valid && !i_upd_jump) begin
                    r_ghr <= GHR_W'({r_ghr, i_upd_taken});
                end
            end
            if (GHR_W >= IDX_W) begin : g_trunc
                assign w_ghr_x = r_ghr[IDX_W-1:0];
            end else begin : g_ext
                assign w_ghr_x = IDX_W'(r_ghr);
            end
        end else begin : g_bimodal
            assign w_ghr_x = '0;
        end

        if (TAG_HI + 1 < XLEN) begin : g_pc_hi
            assign w_unused_hi = ^i_upd_pc[XLEN-1:TAG_HI+1];
        end else begin : g_pc_full
            assign w_unused_hi = 1'b0;
        end
    endgenerate

    assign w_unused = ^{i_upd_pc[1:0], w_unused_hi};

    // Saturating counter step; jumps force strongly taken.
    always_comb begin
        w_cnt_nxt = w_cnt_cur;
        if (i_upd_jump) begin
            w_cnt_nxt = 2'b11;
        end else if (i_upd_taken) begin
            if (w_cnt_cur != 2'b11) w_cnt_nxt = w_cnt_cur + 2'd1;
        end else begin
            if (w_cnt_cur != 2'b00) w_cnt_nxt = w_cnt_cur - 2'd1;
        end
    end

    // Tables: reads above are combinational on the old contents, so same-cycle lookups are read-first.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_btb_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_cnt[i] <= CNT_INIT;
            end
        end else if (i_upd_valid) begin
            r_cnt[w_upd_bht] <= w_cnt_nxt;
            if (i_upd_taken) begin
                r_btb_valid[w_upd_idx] <= 1'b1;
                r_btb_tag[w_upd_idx]   <= w_upd_tag;
                r_btb_tgt[w_upd_idx]   <= i_upd_target;
            end
        end
    end

    // Prediction registers: stall holds everything, an idle cycle only drops valid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_pred_valid  <= 1'b0;
            o_pred_hit    <= 1'b0;
            o_pred_taken  <= 1'b0;
            o_pred_target <= '0;
        end else if (!i_lk_stall) begin
            if (i_lk_valid) begin
                o_pred_valid  <= 1'b1;
                o_pred_hit    <= w_lk_hit;
                o_pred_taken  <= w_lk_taken;
                o_pred_target <= w_lk_taken ? r_btb_tgt[w_lk_idx] : i_lk_pc + XLEN'(4);
            end else begin
                o_pred_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench: bimodal instance driven from a vector table, gshare instance checked by hand sequences.
module tb_branch_predictor_btb;

    logic        clk = 1'b0;
    logic        rst;
    logic        lk_valid, lk_stall;
    logic [31:0] lk_pc;
    logic        upd_valid, upd_taken, upd_jump;
    logic [31:0] upd_pc, upd_target;

    logic        b_valid, b_hit, b_taken;
    logic [31:0] b_target;
    logic        g_valid, g_hit, g_taken;
    logic [31:0] g_target;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predictor_btb #(.GHR_W(0)) dut_b (
        .i_clk(clk), .i_rst(rst),
        .i_lk_valid(lk_valid), .i_lk_stall(lk_stall), .i_lk_pc(lk_pc),
        .o_pred_valid(b_valid), .o_pred_hit(b_hit), .o_pred_taken(b_taken), .o_pred_target(b_target),
        .i_upd_valid(upd_valid), .i_upd_pc(upd_pc), .i_upd_taken(upd_taken),
        .i_upd_jump(upd_jump), .i_upd_target(upd_target)
    );

    branch_predictor_btb #(.GHR_W(4)) dut_g (
        .i_clk(clk), .i_rst(rst),
        .i_lk_valid(lk_valid), .i_lk_stall(lk_stall), .i_lk_pc(lk_pc),
        .o_pred_valid(g_valid), .o_pred_hit(g_hit), .o_pred_taken(g_taken), .o_pred_target(g_target),
        .i_upd_valid(upd_valid), .i_upd_pc(upd_pc), .i_upd_taken(upd_taken),
        .i_upd_jump(upd_jump), .i_upd_target(upd_target)
    );

    typedef struct {
        logic        lv, ls;
        logic [31:0] lpc;
        logic        uv, ut, uj;
        logic [31:0] upc, utg;
        logic        ev, eh, et;
        logic [31:0] etg;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic lv, input logic ls, input logic [31:0] lpc,
                                input logic uv, input logic [31:0] upc, input logic ut,
                                input logic uj, input logic [31:0] utg,
                                input logic ev, input logic eh, input logic et,
                                input logic [31:0] etg);
        vec_t v;
        v.lv = lv; v.ls = ls; v.lpc = lpc;
        v.uv = uv; v.upc = upc; v.ut = ut; v.uj = uj; v.utg = utg;
        v.ev = ev; v.eh = eh; v.et = et; v.etg = etg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic lv, input logic ls, input logic [31:0] lpc,
                          input logic uv, input logic [31:0] upc, input logic ut,
                          input logic uj, input logic [31:0] utg);
        lk_valid = lv; lk_stall = ls; lk_pc = lpc;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_jump = uj; upd_target = utg;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_g(input string tag, input logic ev, input logic eh, input logic et,
                         input logic [31:0] etg);
        chk({tag, ".valid"}, 32'(g_valid), 32'(ev));
        chk({tag, ".hit"}, 32'(g_hit), 32'(eh));
        chk({tag, ".taken"}, 32'(g_taken), 32'(et));
        chk({tag, ".target"}, g_target, etg);
    endtask

    initial begin
        // lv ls lpc | uv upc ut uj utg | ev eh et etg   (bimodal, idx=pc[7:2], tag=pc[15:8])
        vecs.push_back(mk(1,0,32'h100, 0,32'h0,0,0,32'h0,    1,0,0,32'h104));
        vecs.push_back(mk(0,0,32'h0,   1,32'h100,1,0,32'h40, 0,0,0,32'h104));
        vecs.push_back(mk(1,0,32'h100, 0,32'h0,0,0,32'h0,    1,1,1,32'h40));
        vecs.push_back(mk(1,0,32'h100, 1,32'h100,0,0,32'h0,  1,1,1,32'h40));
        vecs.push_back(mk(1,0,32'h100, 1,32'h100,0,0,32'h0,  1,1,0,32'h104));
        vecs.push_back(mk(1,0,32'h100, 1,32'h100,0,0,32'h0,  1,1,0,32'h104));
        vecs.push_back(mk(1,0,32'h100, 1,32'h100,0,0,32'h0,  1,1,0,32'h104));
        vecs.push_back(mk(1,0,32'h100, 0,32'h0,0,0,32'h0,    1,1,0,32'h104));
        vecs.push_back(mk(1,0,32'h100, 1,32'h100,1,0,32'h40, 1,1,0,32'h104));
        vecs.push_back(mk(1,0,32'h100, 1,32'h100,1,0,32'h40, 1,1,0,32'h104));
        vecs.push_back(mk(1,0,32'h100, 1,32'h100,1,0,32'h40, 1,1,1,32'h40));
        vecs.push_back(mk(1,0,32'h100, 1,32'h100,1,0,32'h40, 1,1,1,32'h40));
        vecs.push_back(mk(1,0,32'h100, 1,32'h100,0,0,32'h0,  1,1,1,32'h40));
        vecs.push_back(mk(1,0,32'h100, 0,32'h0,0,0,32'h0,    1,1,1,32'h40));
        vecs.push_back(mk(0,0,32'h0,   1,32'h200,1,0,32'h80, 0,1,1,32'h40));
        vecs.push_back(mk(1,0,32'h100, 0,32'h0,0,0,32'h0,    1,0,0,32'h104));
        vecs.push_back(mk(1,0,32'h200, 0,32'h0,0,0,32'h0,    1,1,1,32'h80));
        vecs.push_back(mk(1,0,32'h300, 1,32'h300,1,0,32'hC0, 1,0,0,32'h304));
        vecs.push_back(mk(1,0,32'h300, 0,32'h0,0,0,32'h0,    1,1,1,32'hC0));
        vecs.push_back(mk(1,0,32'h404, 1,32'h404,0,0,32'h0,  1,0,0,32'h408));
        vecs.push_back(mk(1,0,32'h404, 0,32'h0,0,0,32'h0,    1,0,0,32'h408));
        vecs.push_back(mk(0,0,32'h0,   1,32'h404,1,1,32'h1000, 0,0,0,32'h408));
        vecs.push_back(mk(1,0,32'h404, 0,32'h0,0,0,32'h0,    1,1,1,32'h1000));
        vecs.push_back(mk(1,1,32'h100, 0,32'h0,0,0,32'h0,    1,1,1,32'h1000));
        vecs.push_back(mk(0,1,32'h100, 0,32'h0,0,0,32'h0,    1,1,1,32'h1000));
        vecs.push_back(mk(1,0,32'h300, 1,32'h300,0,0,32'h0,  1,1,1,32'hC0));
        vecs.push_back(mk(1,0,32'h300, 0,32'h0,0,0,32'h0,    1,1,1,32'hC0));
        vecs.push_back(mk(1,0,32'hFFFFFFFC, 0,32'h0,0,0,32'h0, 1,0,0,32'h0));
        vecs.push_back(mk(0,1,32'h0,   1,32'hFFFFFFFC,1,0,32'h44, 1,0,0,32'h0));
        vecs.push_back(mk(1,0,32'hFFFFFFFC, 0,32'h0,0,0,32'h0, 1,1,1,32'h44));

        // Reset with a competing lookup and update; reset must win.
        rst = 1'b1;
        set_in(1, 0, 32'h100, 1, 32'h100, 1, 0, 32'h40);
        tick();
        tick();
        chk("rst.b_valid", 32'(b_valid), 32'd0);
        chk("rst.b_hit", 32'(b_hit), 32'd0);
        chk("rst.b_taken", 32'(b_taken), 32'd0);
        chk("rst.b_target", b_target, 32'd0);
        chk_g("rst.g", 0, 0, 0, 32'h0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            set_in(vecs[i].lv, vecs[i].ls, vecs[i].lpc, vecs[i].uv, vecs[i].upc,
                   vecs[i].ut, vecs[i].uj, vecs[i].utg);
            tick();
            chk($sformatf("v%0d.valid", i), 32'(b_valid), 32'(vecs[i].ev));
            chk($sformatf("v%0d.hit", i), 32'(b_hit), 32'(vecs[i].eh));
            chk($sformatf("v%0d.taken", i), 32'(b_taken), 32'(vecs[i].et));
            chk($sformatf("v%0d.target", i), b_target, vecs[i].etg);
        end

        // Gshare: history build-up, history-indexed counters, jump leaves history alone.
        rst = 1'b1;
        set_in(0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
        tick();
        rst = 1'b0;
        chk("g.ghr_rst", 32'(dut_g.g_gshare.r_ghr), 32'h0);
        set_in(0, 0, 32'h0, 1, 32'h100, 1, 0, 32'h40);
        tick();
        chk("g.ghr_t", 32'(dut_g.g_gshare.r_ghr), 32'h1);
        set_in(0, 0, 32'h0, 1, 32'h100, 1, 0, 32'h40);
        tick();
        set_in(0, 0, 32'h0, 1, 32'h100, 0, 0, 32'h0);
        tick();
        chk("g.ghr_ttn", 32'(dut_g.g_gshare.r_ghr), 32'h6);
        set_in(1, 0, 32'h100, 0, 32'h0, 0, 0, 32'h0);
        tick();
        chk_g("g.lk_idx6", 1, 1, 0, 32'h104);
        set_in(0, 0, 32'h0, 1, 32'h100, 1, 1, 32'h40);
        tick();
        chk("g.ghr_jump", 32'(dut_g.g_gshare.r_ghr), 32'h6);
        set_in(1, 0, 32'h100, 0, 32'h0, 0, 0, 32'h0);
        tick();
        chk_g("g.lk_jump", 1, 1, 1, 32'h40);

        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 32'h200 + 32'(i * 4), 0, 32'h0, 0, 0, 32'h0);
            tick();
            chk_g($sformatf("g.stall%0d", i), 1, 1, 1, 32'h40);
        end

        // Mid-stream reset clears outputs, history and tables.
        rst = 1'b1;
        set_in(1, 0, 32'h100, 0, 32'h0, 0, 0, 32'h0);
        tick();
        rst = 1'b0;
        chk_g("g.rst2", 0, 0, 0, 32'h0);
        chk("g.ghr_rst2", 32'(dut_g.g_gshare.r_ghr), 32'h0);
        chk("b.rst2_valid", 32'(b_valid), 32'd0);
        chk("b.rst2_target", b_target, 32'd0);
        tick();
        chk_g("g.after_rst", 1, 0, 0, 32'h104);
        chk("b.after_rst_hit", 32'(b_hit), 32'd0);
        chk("b.after_rst_target", b_target, 32'h104);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
